// File: rtl/itcm_ctrl_pkg.sv
// ============================================================================
// itcm_ctrl_pkg : shared ITCM address/size constants and FSM state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package itcm_ctrl_pkg;

   localparam int          ZCRV_ADDR_SIZE  = 32;
   localparam int          ZCRV_INSTR_SIZE = 32;
   localparam logic [31:0] ITCM_BASE_DEF   = 32'h8000_0000;
   localparam int          ITCM_AW_DEF     = 14;
   localparam int          ITCM_BYTES_DEF  = 4 * (2 ** ITCM_AW_DEF);

   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_BOOT = 2'd1,
      ST_RUN  = 2'd2
   } itcm_state_e;

endpackage

`default_nettype wire

// File: rtl/itcm_sram.sv
// ============================================================================
// itcm_sram : single-port 32-bit byte-writable array, 1-cycle synchronous read
// Rev 1.0
// ============================================================================
`default_nettype none

module itcm_sram #(
   parameter int AW = 14
) (
   input  logic          clk,
   input  logic          en_i,
   input  logic [3:0]    we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [0:(2**AW)-1];
   logic [31:0] rdata_q;

   // No reset: contents are only cleared by the controller's zero-fill pass.
   always_ff @(posedge clk) begin
      if (en_i) begin
         if (we_i == 4'b0000) begin
            rdata_q <= mem_q[addr_i];
         end else begin
            for (int b = 0; b < 4; b++) begin
               if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/itcm_ctrl.sv
// ============================================================================
// itcm_ctrl : instruction TCM controller (zero-fill, boot load, fetch/run)
// Rev 1.0
// ============================================================================
`default_nettype none

module itcm_ctrl
   import itcm_ctrl_pkg::*;
#(
   parameter int          ITCM_AW   = ITCM_AW_DEF,
   parameter logic [31:0] ITCM_BASE = ITCM_BASE_DEF,
   parameter bit          CLR_EN    = 1'b1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       ifu_to_itcm_req,
   input  logic [ZCRV_ADDR_SIZE-1:0]  pc_to_itcm,
   output logic                       itcm_ready,
   output logic [ZCRV_INSTR_SIZE-1:0] itcm_inst,
   input  logic                       ld_valid,
   output logic                       ld_ready,
   input  logic [ZCRV_ADDR_SIZE-1:0]  ld_addr,
   input  logic [31:0]                ld_wdata,
   input  logic [3:0]                 ld_wstrb,
   input  logic                       ld_done,
   output logic                       itcm_busy
);

   itcm_state_e                state_q;
   logic [ITCM_AW-1:0]         cnt_q;
   logic                       ready_q;
   logic                       oor_q;
   logic [ZCRV_INSTR_SIZE-1:0] inst_q;

   logic [ZCRV_ADDR_SIZE-1:0]  w_pc_off, w_ld_off;
   logic                       w_pc_in, w_ld_in, w_fetch, w_ld_wr;
   logic                       w_unused;
   logic                       sram_en;
   logic [3:0]                 sram_we;
   logic [ITCM_AW-1:0]         sram_addr;
   logic [31:0]                sram_wdata, sram_rdata;

   // Subtracting the base first makes addresses below it wrap out of range.
   assign w_pc_off = pc_to_itcm - ITCM_BASE;
   assign w_ld_off = ld_addr - ITCM_BASE;
   assign w_pc_in  = (w_pc_off[ZCRV_ADDR_SIZE-1:ITCM_AW+2] == '0);
   assign w_ld_in  = (w_ld_off[ZCRV_ADDR_SIZE-1:ITCM_AW+2] == '0);
   assign w_unused = ^{w_pc_off[1:0], w_ld_off[1:0]};

   assign ld_ready  = (state_q == ST_BOOT) || ((state_q == ST_RUN) && !ifu_to_itcm_req);
   assign itcm_busy = (state_q != ST_RUN);
   assign w_fetch   = (state_q == ST_RUN) && ifu_to_itcm_req;
   assign w_ld_wr   = ld_valid && ld_ready && w_ld_in;

   always_comb begin
      sram_en    = 1'b0;
      sram_we    = 4'b0000;
      sram_addr  = w_ld_off[ITCM_AW+1:2];
      sram_wdata = ld_wdata;
      if (state_q == ST_INIT) begin
         sram_en    = 1'b1;
         sram_we    = 4'b1111;
         sram_addr  = cnt_q;
         sram_wdata = '0;
      end else if (w_fetch) begin
         sram_en   = w_pc_in;
         sram_addr = w_pc_off[ITCM_AW+1:2];
      end else if (w_ld_wr) begin
         sram_en = 1'b1;
         sram_we = ld_wstrb;
      end
   end

   itcm_sram #(.AW(ITCM_AW)) u_sram (
      .clk     (clk),
      .en_i    (sram_en),
      .we_i    (sram_we),
      .addr_i  (sram_addr),
      .wdata_i (sram_wdata),
      .rdata_o (sram_rdata)
   );

   assign itcm_ready = ready_q;
   assign itcm_inst  = ready_q ? (oor_q ? '0 : sram_rdata) : inst_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CLR_EN ? ST_INIT : ST_BOOT;
         cnt_q   <= '0;
         ready_q <= 1'b0;
         oor_q   <= 1'b0;
         inst_q  <= '0;
      end else begin
         inst_q  <= itcm_inst;
         ready_q <= w_fetch;
         oor_q   <= w_fetch && !w_pc_in;
         case (state_q)
            ST_INIT: begin
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == '1) state_q <= ST_BOOT;
            end
            ST_BOOT: begin
               if (ld_done) state_q <= ST_RUN;
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire
